textlcd_buf: RTL and testbench
==============================

# textlcd_buf

Parametrised character-LCD controller for HD44780-compatible text panels. It owns an internal LINES×COLS character buffer that the host writes through a simple write port. The block runs the power-up init sequence once, then repaints the panel from the buffer whenever the buffer changes, or after REFRESH_WAIT ticks at the latest. It sits between application logic and the board's text-LCD header.

## Interface
- `DIV`, default 500000: system clocks per LCD tick. Must be ≥ 2. 500000 gives 100 Hz at 50 MHz.
- `LINES`, default 2: display lines. Legal values: 1 or 2.
- `COLS`, default 16: characters per line. Legal range: 1..40.
- `INIT_WAIT`, default 70: ticks to wait after reset before the first command.
- `CLR_WAIT`, default 2: extra ticks to wait after the clear command.
- `REFRESH_WAIT`, default 400: idle ticks before a forced repaint.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Synchronous, active-low.
- `wr_en`, in, 1: buffer write strobe. One write per cycle.
- `wr_line`, in, 1: line index for the write.
- `wr_col`, in, 6: column index for the write.
- `wr_char`, in, 8: ASCII code to store.
- `ready`, out, 1: init sequence complete.
- `busy`, out, 1: a repaint frame is in progress.
- `lcd_e`, out, 1: LCD enable.
- `lcd_rs`, out, 1: LCD register select. 0 = command, 1 = data.
- `lcd_rw`, out, 1: LCD read/write. Always 0.
- `lcd_data`, out, 8: LCD data bus.

## Operation
- **Reset** (`rst`=0 sampled at `clk`):
  - State goes to PWRUP; tick divider, all counters and `dirty` go to 0.
  - Every buffer cell is set to 0x20.
  - Outputs: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `ready`=0, `busy`=0.
- **Tick generation**: the `tick` signal pulses for one `clk` cycle every DIV clocks. All LCD state changes happen only on tick cycles.
- **Command slot**: every command or character write takes 3 ticks.
  - Phase 0: drive `lcd_rs` and `lcd_data`; `lcd_e`=0.
  - Phase 1: `lcd_e`=1.
  - Phase 2: `lcd_e`=0, with `lcd_rs` and `lcd_data` held.
  - The panel latches on the falling edge of `lcd_e`.
- **State machine**:
  - PWRUP: wait INIT_WAIT ticks, then go to FUNC.
  - FUNC: send 0x38 if LINES=2, 0x30 if LINES=1. Then go to DISP.
  - DISP: send 0x0C. Then go to ENTRY.
  - ENTRY: send 0x06. Then go to CLEAR.
  - CLEAR: send 0x01, then wait CLR_WAIT ticks. Set `ready`=1 and go to ADDR with line=0.
  - ADDR: send 0x80 for line 0 or 0xC0 for line 1. Then go to CHAR with col=0.
  - CHAR: send `buf[line][col]` with `rs`=1 for col = 0..COLS-1. After the last column, go to ADDR with line+1 if lines remain, otherwise go to IDLE.
  - IDLE: `lcd_e`=0 and `lcd_rs`=0. Go to ADDR (line 0) when `dirty`=1 or when the idle counter reaches REFRESH_WAIT.
- **Busy**: `busy`=1 from entry to ADDR (line 0) until the return to IDLE.
- **Dirty flag**:
  - Set by any accepted write.
  - Cleared when ADDR for line 0 is entered.
  - A write during a frame therefore sets `dirty` again, and one further frame follows.
- **Write port**:
  - A write is accepted in any state, including before `ready`, and takes effect on the same clock edge.
  - Writes with `wr_col` ≥ COLS, or with `wr_line`=1 when LINES=1, are ignored: no buffer change, no `dirty`.
  - If a write and a CHAR read of the same cell fall in the same cycle, the read returns the old value. The `dirty` flag guarantees the new value appears in the next frame.
- **Reset mid-operation**: all state is discarded and the full init sequence reruns. Any slot in progress is abandoned with `lcd_e` forced to 0.

## Timing
- Write-to-display latency from IDLE is at most 1 tick to reach ADDR, plus 3·(1+COLS)·LINES ticks.
- One frame takes 3·(1+COLS)·LINES ticks. With default parameters that is 102 ticks.
- `ready` rises INIT_WAIT + 12 + CLR_WAIT ticks after reset release.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- `lcd_e` high time is exactly DIV clocks. Setup and hold times are DIV clocks each.

## Structure
- Package `textlcd_pkg`:
  - State enum.
  - Command constants: CMD_FUNC_2L/1L, CMD_DISP_ON, CMD_ENTRY, CMD_CLEAR, DDRAM_L0 = 0x80, DDRAM_L1 = 0xC0.
  - ASCII_SPACE = 0x20.
- Sub-module `textlcd_tick`:
  - Parameter: DIV.
  - Ports: `clk`, `rst`, output `tick`.
  - A single-cycle strobe every DIV clocks.

## Test plan
Benches run with DIV=4, INIT_WAIT=3, CLR_WAIT=1, REFRESH_WAIT=20.
- **Reset and init:** release `rst` and monitor `lcd_data` at each `lcd_e` fall → sequence 0x38, 0x0C, 0x06, 0x01. `ready` rises 16 ticks after release.
- **Default buffer:** run one frame with no writes → 0x80, then 16×0x20 with `rs`=1, then 0xC0, then 16×0x20.
- **Single write:** write (line1, col3, 0x57) while in IDLE → the next frame starts within 1 tick. Line 1, col 3 data is 0x57; all other cells are 0x20.
- **Write during frame and out-of-range writes:**
  - Write during a frame → `dirty` is set and a second frame follows immediately.
  - Write with `wr_col`=16 → ignored: no extra frame, buffer unchanged.
- **Forced refresh:** with no writes for 20 idle ticks → a repaint starts.
- **Reset mid-frame:** assert `rst` during CHAR → `lcd_e`=0 on the next edge, buffer reads 0x20, and the init sequence restarts.

Source files
------------

// File: rtl/textlcd_pkg.sv
// State encoding and HD44780 command bytes shared by the text-LCD controller.
package textlcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP, S_FUNC, S_DISP, S_ENTRY, S_CLEAR, S_ADDR, S_CHAR, S_IDLE
  } state_t;

  localparam logic [7:0] CMD_FUNC_2L = 8'h38;
  localparam logic [7:0] CMD_FUNC_1L = 8'h30;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] DDRAM_L0    = 8'h80;
  localparam logic [7:0] DDRAM_L1    = 8'hC0;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic [7:0] func_cmd(input int lines);
    return (lines == 2) ? CMD_FUNC_2L : CMD_FUNC_1L;
  endfunction

endpackage

// File: rtl/textlcd_tick.sv
// Free-running divider: one-cycle tick strobe every DIV clocks, first one DIV clocks after reset.
module textlcd_tick #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)              cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/textlcd_buf.sv
// HD44780 text-LCD controller: runs the init sequence, then repaints the panel from an
// internal LINES x COLS buffer whenever it is written or after REFRESH_WAIT idle ticks.
module textlcd_buf
  import textlcd_pkg::*;
#(
  parameter int DIV          = 500000,
  parameter int LINES        = 2,
  parameter int COLS         = 16,
  parameter int INIT_WAIT    = 70,
  parameter int CLR_WAIT     = 2,
  parameter int REFRESH_WAIT = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_line,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       ready,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  localparam int NCELL = LINES * COLS;
  localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 16;

  localparam logic [CW-1:0] INIT_LAST = CW'((INIT_WAIT    > 0) ? INIT_WAIT    - 1 : 0);
  localparam logic [CW-1:0] CLR_LAST  = CW'((CLR_WAIT     > 0) ? CLR_WAIT     - 1 : 0);
  localparam logic [CW-1:0] REFR_LAST = CW'((REFRESH_WAIT > 0) ? REFRESH_WAIT - 1 : 0);
  localparam logic [5:0]    COL_LAST  = 6'(COLS - 1);
  localparam logic          LINE_LAST = 1'(LINES - 1);

  function automatic logic [AW-1:0] cell_addr(input logic ln, input logic [5:0] cl);
    return AW'(int'(ln) * COLS + int'(cl));
  endfunction

  logic          tick;
  logic [7:0]    cells [DEPTH];
  state_t        state;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic          line;
  logic [5:0]    col;
  logic          dirty;
  logic          wr_ok;
  logic          slot_rs;
  logic [7:0]    slot_dat;

  textlcd_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign wr_ok  = wr_en && (int'(wr_col) < COLS) && (LINES == 2 || !wr_line);
  assign lcd_rw = 1'b0;

  // Byte and register select for the slot the current state sends.
  always_comb begin
    slot_rs  = 1'b0;
    slot_dat = 8'h00;
    case (state)
      S_FUNC:  slot_dat = func_cmd(LINES);
      S_DISP:  slot_dat = CMD_DISP_ON;
      S_ENTRY: slot_dat = CMD_ENTRY;
      S_CLEAR: slot_dat = CMD_CLEAR;
      S_ADDR:  slot_dat = line ? DDRAM_L1 : DDRAM_L0;
      S_CHAR: begin
        slot_rs  = 1'b1;
        slot_dat = cells[cell_addr(line, col)];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_PWRUP;
      phase    <= 2'd0;
      cnt      <= '0;
      line     <= 1'b0;
      col      <= 6'd0;
      dirty    <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      for (int i = 0; i < DEPTH; i++) cells[AW'(i)] <= ASCII_SPACE;
    end else begin
      if (wr_ok) cells[cell_addr(wr_line, wr_col)] <= wr_char;

      if (tick) begin
        case (state)
          S_PWRUP: begin
            if (cnt >= INIT_LAST) begin
              cnt   <= '0;
              state <= S_FUNC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_IDLE: begin
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            if (dirty || cnt >= REFR_LAST) begin
              cnt   <= '0;
              line  <= 1'b0;
              busy  <= 1'b1;
              dirty <= 1'b0;
              state <= S_ADDR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            // Three-tick slot; phase 3 is only used for the post-clear wait.
            case (phase)
              2'd0: begin
                lcd_e    <= 1'b0;
                lcd_rs   <= slot_rs;
                lcd_data <= slot_dat;
                phase    <= 2'd1;
              end
              2'd1: begin
                lcd_e <= 1'b1;
                phase <= 2'd2;
              end
              2'd2: begin
                lcd_e <= 1'b0;
                phase <= 2'd0;
                case (state)
                  S_FUNC:  state <= S_DISP;
                  S_DISP:  state <= S_ENTRY;
                  S_ENTRY: state <= S_CLEAR;
                  S_CLEAR: begin
                    if (CLR_WAIT == 0) begin
                      ready <= 1'b1;
                      busy  <= 1'b1;
                      dirty <= 1'b0;
                      line  <= 1'b0;
                      state <= S_ADDR;
                    end else begin
                      phase <= 2'd3;
                    end
                  end
                  S_ADDR: begin
                    col   <= 6'd0;
                    state <= S_CHAR;
                  end
                  S_CHAR: begin
                    if (col == COL_LAST) begin
                      if (line == LINE_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                      end else begin
                        line  <= 1'b1;
                        state <= S_ADDR;
                      end
                    end else begin
                      col <= col + 6'd1;
                    end
                  end
                  default: ;
                endcase
              end
              default: begin
                if (cnt >= CLR_LAST) begin
                  cnt   <= '0;
                  phase <= 2'd0;
                  ready <= 1'b1;
                  busy  <= 1'b1;
                  dirty <= 1'b0;
                  line  <= 1'b0;
                  state <= S_ADDR;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            endcase
          end
        endcase
      end

      // A write landing on the same edge as frame start must still force one more frame.
      if (wr_ok) dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_textlcd_buf.sv
// Bench for textlcd_buf: byte-stream model of the panel traffic plus directed timing checks.
module tb_textlcd_buf;

  localparam int DIV   = 4;
  localparam int COLS  = 16;
  localparam int FBYTES = 34;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_line = 1'b0;
  logic [5:0] wr_col = 6'd0;
  logic [7:0] wr_char = 8'h00;
  logic       ready, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  textlcd_buf #(
    .DIV(DIV), .LINES(2), .COLS(COLS), .INIT_WAIT(3), .CLR_WAIT(1), .REFRESH_WAIT(20)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
    .wr_char(wr_char), .ready(ready), .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  // Model: what the panel should hold, and where in the byte stream we are.
  logic [7:0] mbuf [2][COLS];
  logic [8:0] frame_bytes [FBYTES];
  logic [8:0] init_bytes [4];
  bit         in_init = 1'b1;
  int         init_pos = 0;
  int         frame_pos = 0;
  int         frames_done = 0;
  int         hi_cnt = 0;
  logic       prev_e = 1'b0;
  logic [8:0] rise_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [8:0] expected_at(input bit init, input int pos);
    if (init) begin
      case (pos)
        0:       return {1'b0, 8'h38};
        1:       return {1'b0, 8'h0C};
        2:       return {1'b0, 8'h06};
        default: return {1'b0, 8'h01};
      endcase
    end
    if (pos == 0)  return {1'b0, 8'h80};
    if (pos < 17)  return {1'b1, mbuf[0][pos-1]};
    if (pos == 17) return {1'b0, 8'hC0};
    return {1'b1, mbuf[1][pos-18]};
  endfunction

  // Every falling edge of lcd_e is a latched byte; compare it with the model stream.
  always @(negedge clk) begin
    logic [8:0] got;
    check("lcd_rw_low", {31'd0, lcd_rw}, 32'd0);
    if (!rst) begin
      in_init   = 1'b1;
      init_pos  = 0;
      frame_pos = 0;
      hi_cnt    = 0;
      for (int l = 0; l < 2; l++)
        for (int c = 0; c < COLS; c++) mbuf[l][c] = 8'h20;
    end else if (lcd_e) begin
      if (!prev_e) rise_val = {lcd_rs, lcd_data};
      hi_cnt++;
    end else if (prev_e) begin
      got = {lcd_rs, lcd_data};
      check("latched_byte", {23'd0, got},
            {23'd0, expected_at(in_init, in_init ? init_pos : frame_pos)});
      check("held_while_e_high", {23'd0, got}, {23'd0, rise_val});
      check("e_high_clocks", hi_cnt, DIV);
      hi_cnt = 0;
      if (in_init) begin
        init_bytes[init_pos] = got;
        init_pos++;
        if (init_pos == 4) in_init = 1'b0;
      end else begin
        frame_bytes[frame_pos] = got;
        frame_pos++;
        if (frame_pos == FBYTES) begin
          frame_pos = 0;
          frames_done++;
        end
      end
    end
    prev_e = lcd_e;
  end

  task automatic wait_busy(input logic want, input int limit, output int n);
    n = 0;
    while (busy !== want && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== want) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: busy=%b after %0d clocks, expected %b", busy, n, want);
    end
  endtask

  task automatic write_cell(input logic ln, input int c, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_line = ln;
    wr_col  = 6'(c);
    wr_char = ch;
    if (c < COLS) mbuf[ln][c] = ch;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic release_and_wait_ready(input string name);
    int n;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, 16 * DIV);
    check("busy_with_ready", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_lcd_e",    {31'd0, lcd_e},    32'd0);
    check("rst_lcd_rs",   {31'd0, lcd_rs},   32'd0);
    check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    check("rst_ready",    {31'd0, ready},    32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);

    release_and_wait_ready("ready_latency_clocks");
    check("init_byte0", {23'd0, init_bytes[0]}, 32'h038);
    check("init_byte1", {23'd0, init_bytes[1]}, 32'h00C);
    check("init_byte2", {23'd0, init_bytes[2]}, 32'h006);
    check("init_byte3", {23'd0, init_bytes[3]}, 32'h001);

    // First frame, default buffer.
    wait_busy(1'b0, 1000, n);
    check("frame_clocks", n, 102 * DIV);
    @(negedge clk); #1;
    check("frames_done_1", frames_done, 1);
    check("f1_addr_l0", {23'd0, frame_bytes[0]},  32'h080);
    check("f1_l0c0",    {23'd0, frame_bytes[1]},  32'h120);
    check("f1_addr_l1", {23'd0, frame_bytes[17]}, 32'h0C0);
    check("f1_l1c15",   {23'd0, frame_bytes[33]}, 32'h120);

    // Single write from IDLE starts a frame within one tick.
    write_cell(1'b1, 3, 8'h57);
    wait_busy(1'b1, 100, n);
    check("write_to_frame_within_tick", {31'd0, n <= DIV}, 32'd1);
    wait_busy(1'b0, 1000, n);
    @(negedge clk); #1;
    check("f2_l1c3", {23'd0, frame_bytes[21]}, 32'h157);
    check("f2_l1c2", {23'd0, frame_bytes[20]}, 32'h120);

    // Out-of-range column is ignored, so the next frame is the forced refresh.
    @(posedge clk); #1;
    write_cell(1'b0, 16, 8'h58);
    wait_busy(1'b1, 300, n);
    check("refresh_gap_clocks", 2 + n, 20 * DIV);

    // Write during a frame forces one back-to-back frame.
    write_cell(1'b1, 5, 8'h41);
    wait_busy(1'b0, 1000, n);
    wait_busy(1'b1, 100, n);
    check("dirty_gap_clocks", n, DIV);
    wait_busy(1'b0, 1000, n);
    @(negedge clk); #1;
    check("f5_l1c5", {23'd0, frame_bytes[23]}, 32'h141);
    check("f5_l1c0", {23'd0, frame_bytes[18]}, 32'h120);

    // Reset while lcd_e is high in a character slot.
    wait_busy(1'b1, 300, n);
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_char_slot", {31'd0, lcd_e && lcd_rs}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_lcd_e", {31'd0, lcd_e}, 32'd0);
    check("midrst_busy",  {31'd0, busy},  32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    release_and_wait_ready("ready_latency_after_midrst");
    wait_busy(1'b0, 1000, n);
    @(negedge clk); #1;
    check("post_rst_l1c3", {23'd0, frame_bytes[21]}, 32'h120);
    check("post_rst_l1c5", {23'd0, frame_bytes[23]}, 32'h120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
